// File: rtl/cnn_seq_ctrl.sv
// Frame sequencer for the two-layer CNN datapath: streams the image, tracks layer progress, latches the class.
// Define CNN_SEQ_WATCHDOG_EN to add a DRAIN-phase stall watchdog (limit TMO cycles).
module cnn_seq_ctrl #(
  parameter int IX  = 28,
  parameter int IY  = 28,
  parameter int K   = 5,
  parameter int TMO = 4096
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  output logic                         o_busy,
  output logic                         o_img_rd,
  output logic [$clog2(IX*IY)-1:0]     o_img_addr,
  input  logic [7:0]                   i_img_data,
  output logic                         o_pix_valid,
  output logic [7:0]                   o_pix,
  input  logic                         i_conv1_valid,
  input  logic                         i_pool1_valid,
  input  logic                         i_conv2_valid,
  input  logic                         i_cls_valid,
  input  logic [7:0]                   i_cls_alpha,
  output logic                         o_done,
  output logic [7:0]                   o_alpha,
  output logic                         o_err
);

  localparam int NPIX = IX * IY;
  localparam int AW   = $clog2(NPIX);
  localparam int C1   = (IX - K + 1) * (IY - K + 1);
  localparam int P1   = C1 / 4;
  localparam int C2S  = (IX - K + 1) / 2 - K + 1;
  localparam int C2   = C2S * C2S;
  // One spare bit so a runaway datapath saturates well above any expected count.
  localparam int CW   = $clog2(C1 + 1) + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0] C1_V      = CW'(C1);
  localparam logic [CW-1:0] P1_V      = CW'(P1);
  localparam logic [CW-1:0] C2_V      = CW'(C2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] c1_q, c1_d, p1_q, p1_d, c2_q, c2_d;
  logic          pix_valid_q, pix_valid_d;
  logic          err_q, err_d;
  logic [7:0]    alpha_q, alpha_d;
  logic          cnt_clr;
  logic          counts_ok;
  logic          wd_expire;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != {CW{1'b1}})) ? v + CW'(1) : v;
  endfunction

  assign counts_ok = (c1_q == C1_V) && (p1_q == P1_V) && (c2_q == C2_V);

`ifdef CNN_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TMO + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          progress;

  assign progress = i_conv1_valid | i_pool1_valid | i_conv2_valid;

  // Counter is zero on DRAIN entry because it is held clear outside DRAIN.
  always_comb begin
    wd_d      = '0;
    wd_expire = 1'b0;
    if (state_q == S_DRAIN && !progress) begin
      if (wd_q == WW'(TMO - 1)) wd_expire = 1'b1;
      else                      wd_d      = wd_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  // TMO only has meaning when the watchdog is built in.
  assign wd_expire = 1'b0 && (TMO != 0);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    alpha_d = alpha_q;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_STREAM;
          addr_d  = '0;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      S_STREAM: begin
        if (i_abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (i_cls_valid) begin
          state_d = S_ERR;
          addr_d  = '0;
          alpha_d = i_cls_alpha;
          err_d   = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_cls_valid) begin
          alpha_d = i_cls_alpha;
          if (counts_ok) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else if (wd_expire) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    c1_d = '0;
    p1_d = '0;
    c2_d = '0;
    if (!cnt_clr) begin
      c1_d = sat_inc(c1_q, (state_q != S_IDLE) && i_conv1_valid);
      p1_d = sat_inc(p1_q, (state_q != S_IDLE) && i_pool1_valid);
      c2_d = sat_inc(c2_q, (state_q != S_IDLE) && i_conv2_valid);
    end
  end

  // An abort suppresses the pixel strobe for the read issued in the same cycle.
  assign pix_valid_d = o_img_rd & ~i_abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      c1_q        <= '0;
      p1_q        <= '0;
      c2_q        <= '0;
      pix_valid_q <= 1'b0;
      err_q       <= 1'b0;
      alpha_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      c1_q        <= c1_d;
      p1_q        <= p1_d;
      c2_q        <= c2_d;
      pix_valid_q <= pix_valid_d;
      err_q       <= err_d;
      alpha_q     <= alpha_d;
    end
  end

  assign o_img_rd    = (state_q == S_STREAM);
  assign o_img_addr  = addr_q;
  assign o_busy      = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = err_q;
  assign o_alpha     = alpha_q;
  assign o_pix_valid = pix_valid_q;
  // Read data lands the cycle after the strobe, aligned with the delayed valid.
  assign o_pix       = pix_valid_q ? i_img_data : 8'h00;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Directed bench for cnn_seq_ctrl (28x28 image, K=5, TMO=16).
module tb_cnn_seq_ctrl;
  localparam int IX  = 28;
  localparam int IY  = 28;
  localparam int K   = 5;
  localparam int TMO = 16;
  localparam int AW  = $clog2(IX * IY);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          o_busy;
  logic          o_img_rd;
  logic [AW-1:0] o_img_addr;
  logic [7:0]    i_img_data = 8'h00;
  logic          o_pix_valid;
  logic [7:0]    o_pix;
  logic          i_conv1_valid = 1'b0;
  logic          i_pool1_valid = 1'b0;
  logic          i_conv2_valid = 1'b0;
  logic          i_cls_valid = 1'b0;
  logic [7:0]    i_cls_alpha = 8'h00;
  logic          o_done;
  logic [7:0]    o_alpha;
  logic          o_err;

  int n_pass  = 0;
  int n_total = 0;

  cnn_seq_ctrl #(.IX(IX), .IY(IY), .K(K), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_img_rd(o_img_rd), .o_img_addr(o_img_addr), .i_img_data(i_img_data),
    .o_pix_valid(o_pix_valid), .o_pix(o_pix),
    .i_conv1_valid(i_conv1_valid), .i_pool1_valid(i_pool1_valid), .i_conv2_valid(i_conv2_valid),
    .i_cls_valid(i_cls_valid), .i_cls_alpha(i_cls_alpha),
    .o_done(o_done), .o_alpha(o_alpha), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Image buffer: registered read, contents derived from the address.
  always @(posedge clk) i_img_data <= o_img_rd ? (o_img_addr[7:0] ^ 8'h5A) : 8'h00;

  function automatic logic [7:0] pix_of(input int n);
    logic [7:0] b;
    b = n[7:0];
    return b ^ 8'h5A;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if ({o_busy, o_img_rd, o_pix_valid, o_done, o_err} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {o_busy, o_img_rd, o_pix_valid, o_done, o_err}); else n_pass++;
    n_total++; if ({o_img_addr, o_pix, o_alpha} !== '0) $display("FAIL reset_buses got addr=%0d pix=%h alpha=%h want 0", o_img_addr, o_pix, o_alpha); else n_pass++;
    reset_n = 1'b1;
    repeat (2) step();
    n_total++; if ({o_busy, o_img_rd, o_pix_valid} !== 3'b0) $display("FAIL reset_idle got %b want 000", {o_busy, o_img_rd, o_pix_valid}); else n_pass++;
  endtask

  task automatic test_nominal(input string tag);
    logic       exp_rd, exp_pv;
    logic [7:0] exp_pix;
    start_frame();
    for (int c = 1; c <= 785; c++) begin
      exp_rd  = (c <= 784);
      exp_pv  = (c >= 2);
      exp_pix = exp_pv ? pix_of(c - 2) : 8'h00;
      n_total++; if ({o_img_rd, o_pix_valid, o_pix} !== {exp_rd, exp_pv, exp_pix}) $display("FAIL %s_stream cycle %0d got rd=%b pv=%b pix=%h want rd=%b pv=%b pix=%h", tag, c, o_img_rd, o_pix_valid, o_pix, exp_rd, exp_pv, exp_pix); else n_pass++;
      if (exp_rd) begin
        n_total++; if (o_img_addr !== AW'(c - 1)) $display("FAIL %s_addr cycle %0d got %0d want %0d", tag, c, o_img_addr, c - 1); else n_pass++;
      end
      i_conv1_valid = (c <= 576);
      i_pool1_valid = (c <= 144);
      i_conv2_valid = (c <= 64);
      if (c < 785) step();
    end
    n_total++; if (o_busy !== 1'b1) $display("FAIL %s_drain_busy got %b want 1", tag, o_busy); else n_pass++;
    i_cls_valid = 1'b1;
    i_cls_alpha = 8'h41;
    step();
    i_cls_valid = 1'b0;
    n_total++; if ({o_done, o_err, o_busy} !== 3'b100) $display("FAIL %s_done got done/err/busy=%b want 100", tag, {o_done, o_err, o_busy}); else n_pass++;
    n_total++; if (o_alpha !== 8'h41) $display("FAIL %s_alpha got %h want 41", tag, o_alpha); else n_pass++;
    step();
    n_total++; if ({o_done, o_err, o_busy} !== 3'b000) $display("FAIL %s_after_done got done/err/busy=%b want 000", tag, {o_done, o_err, o_busy}); else n_pass++;
    n_total++; if (o_alpha !== 8'h41) $display("FAIL %s_alpha_hold got %h want 41", tag, o_alpha); else n_pass++;
  endtask

  task automatic test_mismatch;
    start_frame();
    for (int c = 1; c <= 784; c++) begin
      i_conv1_valid = (c <= 575);
      i_pool1_valid = (c <= 144);
      i_conv2_valid = (c <= 64);
      step();
    end
    i_cls_valid = 1'b1;
    i_cls_alpha = 8'h5A;
    step();
    i_cls_valid = 1'b0;
    n_total++; if ({o_err, o_done, o_busy} !== 3'b100) $display("FAIL mismatch_err got err/done/busy=%b want 100", {o_err, o_done, o_busy}); else n_pass++;
    n_total++; if (o_alpha !== 8'h5A) $display("FAIL mismatch_alpha got %h want 5a", o_alpha); else n_pass++;
    step();
    n_total++; if ({o_err, o_done, o_busy} !== 3'b100) $display("FAIL mismatch_sticky got err/done/busy=%b want 100", {o_err, o_done, o_busy}); else n_pass++;
  endtask

  task automatic test_abort;
    start_frame();
    n_total++; if (o_err !== 1'b0) $display("FAIL start_clears_err got %b want 0", o_err); else n_pass++;
    repeat (300) step();
    n_total++; if ({o_img_rd, o_img_addr} !== {1'b1, AW'(300)}) $display("FAIL abort_pre got rd=%b addr=%0d want rd=1 addr=300", o_img_rd, o_img_addr); else n_pass++;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    n_total++; if ({o_img_rd, o_pix_valid, o_busy, o_done, o_err} !== 5'b0) $display("FAIL abort_stop got rd/pv/busy/done/err=%b want 00000", {o_img_rd, o_pix_valid, o_busy, o_done, o_err}); else n_pass++;
    repeat (3) step();
    n_total++; if ({o_img_rd, o_pix_valid} !== 2'b0) $display("FAIL abort_quiet got rd/pv=%b want 00", {o_img_rd, o_pix_valid}); else n_pass++;
    start_frame();
    n_total++; if ({o_img_rd, o_img_addr} !== {1'b1, AW'(0)}) $display("FAIL restart_addr0 got rd=%b addr=%0d want rd=1 addr=0", o_img_rd, o_img_addr); else n_pass++;
    step();
    n_total++; if ({o_img_addr, o_pix_valid, o_pix} !== {AW'(1), 1'b1, pix_of(0)}) $display("FAIL restart_addr1 got addr=%0d pv=%b pix=%h want addr=1 pv=1 pix=%h", o_img_addr, o_pix_valid, o_pix, pix_of(0)); else n_pass++;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    step();
  endtask

  task automatic test_start_while_busy;
    start_frame();
    repeat (100) step();
    n_total++; if (o_img_addr !== AW'(100)) $display("FAIL busy_start_pre got addr=%0d want 100", o_img_addr); else n_pass++;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    n_total++; if ({o_img_rd, o_img_addr} !== {1'b1, AW'(101)}) $display("FAIL busy_start_101 got rd=%b addr=%0d want rd=1 addr=101", o_img_rd, o_img_addr); else n_pass++;
    step();
    n_total++; if ({o_busy, o_img_addr} !== {1'b1, AW'(102)}) $display("FAIL busy_start_102 got busy=%b addr=%0d want busy=1 addr=102", o_busy, o_img_addr); else n_pass++;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    step();
  endtask

  task automatic test_cls_in_stream;
    start_frame();
    repeat (10) step();
    i_cls_valid = 1'b1;
    i_cls_alpha = 8'h51;
    step();
    i_cls_valid = 1'b0;
    n_total++; if ({o_err, o_busy, o_img_rd, o_done} !== 4'b1000) $display("FAIL early_cls got err/busy/rd/done=%b want 1000", {o_err, o_busy, o_img_rd, o_done}); else n_pass++;
    n_total++; if (o_alpha !== 8'h51) $display("FAIL early_cls_alpha got %h want 51", o_alpha); else n_pass++;
    step();
    n_total++; if ({o_err, o_busy} !== 2'b10) $display("FAIL early_cls_idle got err/busy=%b want 10", {o_err, o_busy}); else n_pass++;
  endtask

  task automatic test_watchdog;
    start_frame();
    repeat (784) step();
`ifdef CNN_SEQ_WATCHDOG_EN
    repeat (15) step();
    n_total++; if ({o_busy, o_err} !== 2'b10) $display("FAIL wd_pre got busy/err=%b want 10", {o_busy, o_err}); else n_pass++;
    step();
    n_total++; if ({o_err, o_busy, o_done} !== 3'b100) $display("FAIL wd_fire got err/busy/done=%b want 100", {o_err, o_busy, o_done}); else n_pass++;
    step();
    n_total++; if ({o_err, o_busy} !== 2'b10) $display("FAIL wd_idle got err/busy=%b want 10", {o_err, o_busy}); else n_pass++;
`else
    repeat (200) step();
    n_total++; if ({o_busy, o_err, o_done} !== 3'b100) $display("FAIL no_wd_hold got busy/err/done=%b want 100", {o_busy, o_err, o_done}); else n_pass++;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    n_total++; if ({o_busy, o_err, o_done} !== 3'b000) $display("FAIL no_wd_abort got busy/err/done=%b want 000", {o_busy, o_err, o_done}); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_drain;
    start_frame();
    repeat (787) step();
    n_total++; if ({o_busy, o_img_rd} !== 2'b10) $display("FAIL rst_drain_pre got busy/rd=%b want 10", {o_busy, o_img_rd}); else n_pass++;
    n_total++; if (o_alpha !== 8'h51) $display("FAIL rst_drain_alpha_pre got %h want 51", o_alpha); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if ({o_busy, o_img_rd, o_pix_valid, o_done, o_err} !== 5'b0) $display("FAIL rst_async_flags got %b want 00000", {o_busy, o_img_rd, o_pix_valid, o_done, o_err}); else n_pass++;
    n_total++; if ({o_img_addr, o_pix, o_alpha} !== '0) $display("FAIL rst_async_buses got addr=%0d pix=%h alpha=%h want 0", o_img_addr, o_pix, o_alpha); else n_pass++;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    n_total++; if ({o_busy, o_img_rd, o_pix_valid} !== 3'b0) $display("FAIL rst_release_quiet got busy/rd/pv=%b want 000", {o_busy, o_img_rd, o_pix_valid}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal("nominal");
    test_mismatch();
    test_abort();
    test_start_while_busy();
    test_cls_in_stream();
    test_watchdog();
    test_reset_mid_drain();
    test_nominal("post_reset");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
